// File: rtl/fifo_uart_tx.sv
// Drain side of a 16x8 FIFO: pops one byte at a time and sends it as a UART 8N1 frame on tx.
// The read strobe is held off during reset and in any cycle where the producer's write is accepted.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_wr_taken,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          byte_done_q, byte_done_d;
  logic          baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE);
  assign byte_done = byte_done_q;

  // Next-state, counter and shift-register logic; tx follows the state being entered.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    fifo_rd     = 1'b0;
    tx_d        = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rst && !fifo_empty && !fifo_wr_taken) begin
          fifo_rd = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shift_d = fifo_dout;
        baud_d  = '0;
        bit_d   = 3'd0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1'b1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1'b1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d      = '0;
          byte_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          baud_d = baud_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 1'b1;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      byte_done_q <= byte_done_d;
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain side of the 16x8 synchronous FIFO. The block pops one byte at a time through the FIFO read port (`rd`/`dout`/`empty`) and serializes it as a UART 8N1 frame on `tx`. The FIFO gives a write priority over a read in the same cycle and drops the read silently, so this block takes a write-accepted strobe from the producer side and never issues `rd` in a cycle where a write is being accepted.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range is 2 or more.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset (asserted when 0).
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_dout`  in  8: FIFO `dout`; valid in the cycle after an accepted `rd`.
- `fifo_wr_taken`  in  1: high in any cycle where the FIFO accepts a write (`wr && !full`).
- `fifo_rd`  out  1: read strobe to the FIFO.
- `tx`  out  1: serial line; idles high.
- `busy`  out  1: high whenever the state is not IDLE.
- `byte_done`  out  1: one-cycle pulse after a stop bit completes.

## Operation
- The FSM has five states:
  - **IDLE**: waits for data.
  - **LOAD**: captures `fifo_dout` into the 8-bit shift register.
  - **START**: drives the start bit.
  - **DATA**: shifts out 8 bits.
  - **STOP**: drives the stop bit.
- `fifo_rd` is combinational: `fifo_rd = (state==IDLE) && !fifo_empty && !fifo_wr_taken`.
- IDLE -> LOAD on the edge where `fifo_rd` = 1. Otherwise the block stays in IDLE.
- LOAD -> START after exactly 1 cycle; the shift register is loaded from `fifo_dout` on that edge.
- START drives `tx=0` for `CLKS_PER_BIT` cycles, then goes to DATA.
- DATA drives `tx` = shift register bit 0, sending data LSB first. Each bit is held `CLKS_PER_BIT` cycles, then the register shifts right. After 8 bits the FSM goes to STOP.
- STOP drives `tx=1` for `CLKS_PER_BIT` cycles, then returns to IDLE.
- `byte_done` is registered. It is high for exactly the first cycle back in IDLE after STOP.
- Counters:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT`-1, clears on every state or bit change, and is never allowed to wrap mid-bit.
  - Bit index is 3 bits, counting 0..7. Reaching 7 at the end of a bit moves the FSM to STOP.
- `tx` is registered. It is 1 in IDLE and in LOAD.
- Reset (`rst`=0) has priority over everything, including mid-frame. On the next edge:
  - state = IDLE, `tx` = 1, `busy` = 0, `byte_done` = 0.
  - Counters and the shift register clear.
  - `fifo_rd` = 0 while `rst` = 0.
  - A byte already popped is discarded and is not re-read.

## Timing
- Values after reset: `tx`=1, `fifo_rd`=0, `busy`=0, `byte_done`=0.
- Pop to start bit:
  - Cycle k: `fifo_rd`=1.
  - Cycle k+1: LOAD, with `tx` still 1.
  - Cycle k+2: first cycle of the start bit.
- A frame is exactly `10*CLKS_PER_BIT` cycles (START + 8 DATA + STOP).
- Back-to-back with a non-empty FIFO: there are exactly 2 idle-high cycles between a stop bit and the next start bit. These are the IDLE cycle (with `fifo_rd`) and the LOAD cycle.
- At most one `fifo_rd` is issued per frame, and never while `busy`=1.
- Write collision: while `fifo_wr_taken`=1, `fifo_rd` stays 0 and the block remains in IDLE. `fifo_rd` asserts in the first cycle where `fifo_wr_taken`=0 and `fifo_empty`=0.
- `fifo_empty` falling while `busy`=1 has no effect until IDLE.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Reset:** hold `rst`=0 for 3 cycles with `fifo_empty`=0 -> `tx`=1, `fifo_rd`=0, `busy`=0, `byte_done`=0 throughout.
- **Single byte 0xA5:** -> `fifo_rd` high for 1 cycle, then on `tx`:
  - 1 LOAD cycle with `tx`=1.
  - Start bit: `tx`=0 for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1, each for 4 cycles.
  - Stop bit: `tx`=1 for 4 cycles.
  - `byte_done` pulses 1 cycle, 42 cycles after `fifo_rd`.
- **Back-to-back 0x00 then 0xFF:** -> exactly two `fifo_rd` pulses and two 40-cycle frames. The frames are separated by exactly 2 cycles of `tx`=1. The 0xFF frame shows `tx`=1 for 36 cycles after its start bit.
- **Write collision:** FIFO non-empty in IDLE with `fifo_wr_taken`=1 for 5 cycles -> `fifo_rd`=0 for those 5 cycles, then `fifo_rd`=1 in the cycle `fifo_wr_taken` drops.
- **Reset mid-frame:** assert `rst`=0 during DATA bit 3 -> next edge `tx`=1, `busy`=0. After release with `fifo_empty`=0, a new `fifo_rd` occurs in the first post-reset cycle and the next byte transmits in full.
- **Empty FIFO:** `fifo_empty`=1 held for 100 cycles -> `fifo_rd` never asserts, `tx`=1, `busy`=0.
